mem_port_arbiter: RTL

//  Shares the single-port data/instruction memory between instruction fetch (IF) and load/store (LS).

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch (IF) and load/store (LS).
// LS has fixed priority, and a burst counter limits how long IF can be starved.
module mem_port_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 16,
  parameter int WAIT_CYCLES  = 1,
  parameter int MAX_LS_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              ls_req,
  input  logic [1:0]        ls_cmd,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_valid,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_ls
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam int              BURST_W    = $clog2(MAX_LS_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_LS_BURST);
  localparam logic [3:0]      WAIT_INIT  = 4'(WAIT_CYCLES);

  logic [1:0]         state;
  logic               winner_ls;
  logic               lat_write;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [3:0]         wait_cnt;
  logic [BURST_W-1:0] burst_cnt;

  logic ls_ok;
  logic allow_if;
  logic allow_ls;
  logic grant_if;
  logic grant_ls;

  assign ls_ok = ls_req & ls_cmd[1];

  // In RESP only the requester that was not just served may be granted.
  always_comb begin
    allow_if = 1'b0;
    allow_ls = 1'b0;
    if (!halt) begin
      if (state == ST_IDLE) begin
        allow_if = 1'b1;
        allow_ls = 1'b1;
      end else if (state == ST_RESP) begin
        allow_if = winner_ls;
        allow_ls = ~winner_ls;
      end
    end
  end

  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (if_req && allow_if && (burst_cnt == BURST_MAX)) begin
      grant_if = 1'b1;
    end else if (ls_ok && allow_ls) begin
      grant_ls = 1'b1;
    end else if (if_req && allow_if) begin
      grant_if = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      winner_ls <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      wait_cnt  <= '0;
      if_valid  <= 1'b0;
      ls_valid  <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      if_valid <= 1'b0;
      ls_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_RESP: begin
          if (grant_if || grant_ls) begin
            state     <= ST_ACCESS;
            winner_ls <= grant_ls;
            lat_write <= grant_ls & ls_cmd[0];
            lat_addr  <= grant_ls ? ls_addr : if_addr;
            lat_wdata <= grant_ls ? ls_wdata : '0;
            wait_cnt  <= WAIT_INIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          // The RAM presents read data only in the final access cycle.
          if (wait_cnt == 4'd0) begin
            state <= ST_RESP;
            if (winner_ls) begin
              ls_valid <= 1'b1;
              if (!lat_write) begin
                ls_rdata <= mem_rdata;
              end
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Consecutive LS grants only count against IF while IF is actually waiting.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      burst_cnt <= '0;
    end else if (grant_if) begin
      burst_cnt <= '0;
    end else if (grant_ls) begin
      if (!if_req) begin
        burst_cnt <= '0;
      end else if (burst_cnt != BURST_MAX) begin
        burst_cnt <= burst_cnt + BURST_W'(1);
      end
    end
  end

  assign mem_cmd   = (state == ST_ACCESS) ? {1'b1, lat_write} : 2'b00;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  assign stall_if = if_req & ~if_valid;
  assign stall_ls = ls_req & ls_cmd[1] & ~ls_valid;

endmodule
